// File: rtl/pix_stream_tx.sv
//==============================================================================
// Module      : pix_stream_tx
// Description : Reads one 8-bit grayscale frame from a 1-cycle-latency frame
//               RAM and emits it as an AXI-Stream pixel stream, 1 pixel/cycle,
//               through a 2-entry prefetch buffer that absorbs backpressure.
//               Optional macro PIX_STREAM_TX_SOF_EN adds output_axi_user
//               (start-of-frame flag on the first pixel).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pix_stream_tx #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic              ram_ren,
    input  logic [7:0]        ram_rdata,
    output logic [7:0]        output_axi_data,
    output logic              output_axi_valid,
    input  logic              output_axi_ready,
    output logic              output_axi_last,
    output logic              output_axi_keep,
    output logic              busy,
    output logic              done
`ifdef PIX_STREAM_TX_SOF_EN
    ,
    output logic              output_axi_user
`endif
);

    localparam int c_N     = IMG_W * IMG_H;
    localparam int c_CNT_W = $clog2(c_N + 1);

    localparam logic [c_CNT_W-1:0] c_N_CNT    = c_CNT_W'(c_N);
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(c_N - 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_RUN   = 2'd1;
    localparam logic [1:0] c_S_DRAIN = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [ADDR_W-1:0]  r_base;
    logic [c_CNT_W-1:0] r_rd_cnt;
    logic [c_CNT_W-1:0] r_tx_cnt;

    // Read pipeline: flags travel alongside the outstanding RAM read
    logic               r_rvalid;
    logic               r_rlast;
    logic               r_rfirst;

    logic [7:0]         r_buf_data  [0:1];
    logic               r_buf_last  [0:1];
    logic               r_buf_first [0:1];
    logic               r_wptr;
    logic               r_rptr;
    logic [1:0]         r_count;

    logic               w_valid;
    logic               w_pop;
    logic               w_push;
    logic [2:0]         w_pending;
    logic               w_ren;

    assign w_valid = (r_count != 2'd0);
    assign w_pop   = w_valid & output_axi_ready;
    assign w_push  = r_rvalid;

    // Crediting this cycle's pop lets a read issue every cycle under
    // continuous ready while still never overflowing the 2 entries.
    assign w_pending = {1'b0, r_count} + {2'b00, r_rvalid} - {2'b00, w_pop};
    assign w_ren     = (r_state == c_S_RUN) && (r_rd_cnt < c_N_CNT) && (w_pending < 3'd2);

    assign ram_ren   = w_ren;
    assign ram_raddr = r_base + ADDR_W'(r_rd_cnt);

    assign output_axi_valid = w_valid;
    assign output_axi_data  = r_buf_data[r_rptr];
    assign output_axi_last  = w_valid & r_buf_last[r_rptr];
    assign output_axi_keep  = 1'b1;
`ifdef PIX_STREAM_TX_SOF_EN
    assign output_axi_user  = w_valid & r_buf_first[r_rptr];
`endif

    assign busy = (r_state == c_S_RUN) || (r_state == c_S_DRAIN);
    assign done = (r_state == c_S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_S_IDLE;
            r_base   <= '0;
            r_rd_cnt <= '0;
            r_tx_cnt <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_state  <= c_S_RUN;
                        r_base   <= base_addr;
                        r_rd_cnt <= '0;
                        r_tx_cnt <= '0;
                    end
                end
                c_S_RUN: begin
                    if (w_ren) begin
                        r_rd_cnt <= r_rd_cnt + 1'b1;
                    end
                    if (w_pop) begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                    if (r_rd_cnt == c_N_CNT) begin
                        r_state <= c_S_DRAIN;
                    end
                end
                c_S_DRAIN: begin
                    if (w_pop) begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                        if (r_tx_cnt == c_LAST_CNT) begin
                            r_state <= c_S_DONE;
                        end
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_rfirst <= 1'b0;
        end else begin
            r_rvalid <= w_ren;
            r_rlast  <= w_ren && (r_rd_cnt == c_LAST_CNT);
            r_rfirst <= w_ren && (r_rd_cnt == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_buf_data[i]  <= 8'd0;
                r_buf_last[i]  <= 1'b0;
                r_buf_first[i] <= 1'b0;
            end
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_buf_data[r_wptr]  <= ram_rdata;
                r_buf_last[r_wptr]  <= r_rlast;
                r_buf_first[r_wptr] <= r_rfirst;
                r_wptr              <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pix_stream_tx.sv
//==============================================================================
// Module      : tb_pix_stream_tx
// Description : Self-checking bench for pix_stream_tx (4x3 frame plus a 4x1
//               instance with a 4-bit address space for wrap-around).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pix_stream_tx;

    localparam int c_N = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [18:0] base_addr = '0;
    logic [18:0] ram_raddr;
    logic        ram_ren;
    logic [7:0]  ram_rdata = 8'd0;
    logic [7:0]  output_axi_data;
    logic        output_axi_valid;
    logic        output_axi_ready = 1'b0;
    logic        output_axi_last;
    logic        output_axi_keep;
    logic        busy;
    logic        done;
`ifdef PIX_STREAM_TX_SOF_EN
    logic        output_axi_user;
    logic        w_user;
`endif

    logic        w_start = 1'b0;
    logic [3:0]  w_raddr;
    logic        w_ren;
    logic [7:0]  w_rdata = 8'd0;
    logic [7:0]  w_data;
    logic        w_valid;
    logic        w_ready = 1'b1;
    logic        w_last;
    logic        w_keep;
    logic        w_busy;
    logic        w_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pix_stream_tx #(.IMG_W(4), .IMG_H(3), .ADDR_W(19)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .ram_raddr(ram_raddr), .ram_ren(ram_ren), .ram_rdata(ram_rdata),
        .output_axi_data(output_axi_data), .output_axi_valid(output_axi_valid),
        .output_axi_ready(output_axi_ready), .output_axi_last(output_axi_last),
        .output_axi_keep(output_axi_keep), .busy(busy), .done(done)
`ifdef PIX_STREAM_TX_SOF_EN
        , .output_axi_user(output_axi_user)
`endif
    );

    pix_stream_tx #(.IMG_W(4), .IMG_H(1), .ADDR_W(4)) dut_w (
        .clk(clk), .rst(rst), .start(w_start), .base_addr(4'd14),
        .ram_raddr(w_raddr), .ram_ren(w_ren), .ram_rdata(w_rdata),
        .output_axi_data(w_data), .output_axi_valid(w_valid),
        .output_axi_ready(w_ready), .output_axi_last(w_last),
        .output_axi_keep(w_keep), .busy(w_busy), .done(w_done)
`ifdef PIX_STREAM_TX_SOF_EN
        , .output_axi_user(w_user)
`endif
    );

    // Frame RAM models: RAM[a] = a + 1, 1-cycle read latency
    always @(posedge clk) begin
        if (ram_ren) ram_rdata <= 8'(ram_raddr + 19'd1);
        if (w_ren)   w_rdata   <= 8'({4'd0, w_raddr} + 8'd1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready=1; 1: ready 1,0,0,1; 2: ready=0 for 20 cycles; 3: extra start at pixel 5
    task automatic run_frame(input int mode);
        int         exp_next = 1;
        int         beats = 0;
        int         dones = 0;
        int         rens = 0;
        int         post = -1;
        bit         sent = 0;
        bit         fin = 0;
        logic       pv = 0;
        logic       pr = 0;
        logic       pl = 0;
        logic [7:0] pd = 0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            start = (cyc == 0);
            if (mode == 3 && !sent && output_axi_valid && output_axi_data == 8'd5) begin
                start = 1'b1;
                sent  = 1'b1;
            end
            case (mode)
                1:       output_axi_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                2:       output_axi_ready = (cyc >= 20);
                default: output_axi_ready = 1'b1;
            endcase
            @(negedge clk);
            if (ram_ren) rens++;
            if (mode == 2 && cyc == 19) begin
                chk("stall_reads", rens, 2);
                chk("stall_valid", output_axi_valid, 1);
                chk("stall_data", output_axi_data, 1);
            end
            if (pv && !pr) begin
                chk("hold_valid", output_axi_valid, 1);
                chk("hold_data", output_axi_data, pd);
                chk("hold_last", output_axi_last, pl);
            end
`ifdef PIX_STREAM_TX_SOF_EN
            chk("sof_user", output_axi_user, output_axi_valid && exp_next == 1);
`endif
            if (output_axi_valid && output_axi_ready) begin
                chk("beat_data", output_axi_data, exp_next & 255);
                chk("beat_last", output_axi_last, exp_next == c_N);
                beats++;
                exp_next++;
            end
            if (done) begin
                dones++;
                if (post < 0) post = cyc;
            end
            if (post >= 0 && cyc >= post + 4) fin = 1;
            pv = output_axi_valid;
            pr = output_axi_ready;
            pd = output_axi_data;
            pl = output_axi_last;
            next_cycle();
        end
        start = 1'b0;
        chk($sformatf("frame_beats_m%0d", mode), beats, c_N);
        chk($sformatf("frame_dones_m%0d", mode), dones, 1);
    endtask

    typedef struct {
        logic       start;
        logic       ready;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_last;
        logic       exp_busy;
        logic       exp_done;
        logic       exp_ren;
        logic [18:0] exp_addr;
        logic       exp_user;
    } vec_t;

    vec_t tbl[17];

    initial begin
        logic [3:0] addrs[$];
        logic [7:0] datas[$];
        logic       lasts[$];
        bit         found;
        int         late;

        // Continuous-ready frame: start at cycle 0, pixel k valid at cycle k+2
        for (int k = 0; k < 17; k++) begin
            tbl[k].start     = (k == 0);
            tbl[k].ready     = 1'b1;
            tbl[k].exp_valid = (k >= 3) && (k <= 14);
            tbl[k].exp_data  = (k >= 3 && k <= 14) ? 8'(k - 2) : 8'd0;
            tbl[k].exp_last  = (k == 14);
            tbl[k].exp_busy  = (k >= 1) && (k <= 14);
            tbl[k].exp_done  = (k == 15);
            tbl[k].exp_ren   = (k >= 1) && (k <= 12);
            tbl[k].exp_addr  = (k >= 1 && k <= 12) ? 19'(k - 1) : 19'd0;
            tbl[k].exp_user  = (k == 3);
        end

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", output_axi_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ren", ram_ren, 0);
        chk("rst_raddr", ram_raddr, 0);
        chk("rst_data", output_axi_data, 0);
        chk("rst_last", output_axi_last, 0);
        chk("rst_keep", output_axi_keep, 1);
`ifdef PIX_STREAM_TX_SOF_EN
        chk("rst_user", output_axi_user, 0);
`endif
        next_cycle();
        rst = 1'b0;
        next_cycle();

        for (int k = 0; k < 17; k++) begin
            start            = tbl[k].start;
            output_axi_ready = tbl[k].ready;
            @(negedge clk);
            chk($sformatf("t%0d_valid", k), output_axi_valid, tbl[k].exp_valid);
            if (tbl[k].exp_valid) begin
                chk($sformatf("t%0d_data", k), output_axi_data, tbl[k].exp_data);
            end
            chk($sformatf("t%0d_last", k), output_axi_last, tbl[k].exp_last);
            chk($sformatf("t%0d_busy", k), busy, tbl[k].exp_busy);
            chk($sformatf("t%0d_done", k), done, tbl[k].exp_done);
            chk($sformatf("t%0d_ren", k), ram_ren, tbl[k].exp_ren);
            if (tbl[k].exp_ren) begin
                chk($sformatf("t%0d_addr", k), ram_raddr, tbl[k].exp_addr);
            end
`ifdef PIX_STREAM_TX_SOF_EN
            chk($sformatf("t%0d_user", k), output_axi_user, tbl[k].exp_user);
`endif
            next_cycle();
        end
        start = 1'b0;

        run_frame(1);
        run_frame(2);
        run_frame(3);

        // Address wrap on the 4-bit instance: base 14 -> 14,15,0,1
        w_start = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (w_ren) addrs.push_back(w_raddr);
            if (w_valid && w_ready) begin
                datas.push_back(w_data);
                lasts.push_back(w_last);
            end
            next_cycle();
            w_start = 1'b0;
        end
        chk("wrap_reads", addrs.size(), 4);
        chk("wrap_beats", datas.size(), 4);
        if (addrs.size() == 4 && datas.size() == 4) begin
            chk("wrap_addr0", addrs[0], 14);
            chk("wrap_addr1", addrs[1], 15);
            chk("wrap_addr2", addrs[2], 0);
            chk("wrap_addr3", addrs[3], 1);
            chk("wrap_data0", datas[0], 15);
            chk("wrap_data1", datas[1], 16);
            chk("wrap_data2", datas[2], 1);
            chk("wrap_data3", datas[3], 2);
            chk("wrap_last2", lasts[2], 0);
            chk("wrap_last3", lasts[3], 1);
        end

        // Reset in the middle of a frame, at the pixel-6 handshake
        found = 0;
        output_axi_ready = 1'b1;
        start = 1'b1;
        for (int cyc = 0; cyc < 50 && !found; cyc++) begin
            @(negedge clk);
            if (output_axi_valid && output_axi_data == 8'd6) begin
                found = 1;
            end else begin
                next_cycle();
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("rst_mid_reached", found, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_valid", output_axi_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ren", ram_ren, 0);
        chk("rst_mid_last", output_axi_last, 0);
        next_cycle();
        rst = 1'b0;
        late = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (done || output_axi_valid || busy) late++;
            next_cycle();
        end
        chk("rst_mid_quiet", late, 0);

        run_frame(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
